// File: rtl/counter_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// counter_sequencer_pkg
//  Shared definitions for the counter run controller: the FSM state encoding
//  (which is also driven out on the 'state' port, so the numeric values are
//  part of the external interface), the wrap counter ceiling, and a small
//  saturating-increment helper for that counter.
// ---------------------------------------------------------------------------
package counter_sequencer_pkg;

   // Encoding is visible on the state port: IDLE=00 RUN=01 PAUSE=10 DONE=11.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } seq_state_t;

   // The wrap counter sticks at this value instead of rolling over to zero.
   localparam logic [7:0] WRAP_MAX = 8'd255;

   // Increment that holds at WRAP_MAX.
   function automatic logic [7:0] wrap_inc(input logic [7:0] value);
      return (value == WRAP_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/counter_sequencer_rate_divider.sv
// ---------------------------------------------------------------------------
// rate_divider
//  Prescaler for the counter sequencer. It counts 0..PRESCALE-1 while 'run'
//  is high and then wraps. 'tick' is high combinationally on the last count
//  of the period, so the owner can register it into a one-cycle enable.
//  When 'run' is low, the value is frozen. This is what lets a paused run
//  resume mid-period. 'restart' zeroes the value and takes priority over
//  'run'.
//
//  Ports
//   clock    in   1   system clock
//   clear    in   1   asynchronous active-low reset
//   run      in   1   advance the prescaler this cycle
//   restart  in   1   force the prescaler back to zero
//   tick     out  1   last cycle of a prescale period (only while running)
// ---------------------------------------------------------------------------
module rate_divider #(
   parameter int PRESCALE = 50000,
   parameter int PS_W     = $clog2(PRESCALE)
) (
   input  logic clock,
   input  logic clear,
   input  logic run,
   input  logic restart,
   output logic tick
);

   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps;

   // Prescaler register. A restart always wins. Otherwise the value advances
   // only while running and wraps after LAST. This gives a period of exactly
   // PRESCALE cycles of run time between ticks.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ps <= '0;
      end else if (restart) begin
         ps <= '0;
      end else if (run) begin
         if (ps == LAST) begin
            ps <= '0;
         end else begin
            ps <= ps + 1'b1;
         end
      end
   end

   // A tick is only reported on a cycle in which the prescaler actually
   // advances. A frozen prescaler that sits on LAST therefore does not emit
   // a stream of ticks.
   assign tick = run && !restart && (ps == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//  Run controller for an external T-flip-flop up-counter. It turns the
//  debounced start/pause/stop command pulses into registered enable and
//  clear strobes for the counter. Counting steps are paced by an internal
//  prescaler. The block stops the count when the counter's Q feedback
//  equals a terminal value that is latched at start. It can optionally
//  restart by itself (auto-reload) and counts those wraps.
//
//  Ports
//   clock        in   1      system clock, all state on posedge
//   clear        in   1      asynchronous active-low reset
//   start        in   1      command pulse: start from IDLE/DONE, resume from PAUSE
//   pause        in   1      command pulse: freeze counting (RUN only)
//   stop         in   1      command pulse: abort, clear counter, back to IDLE
//   auto_reload  in   1      level: in DONE, restart the run automatically
//   terminal     in   WIDTH  target count, latched on a fresh start
//   count        in   WIDTH  counter Q feedback
//   cnt_en       out  1      one-cycle counter enable per step
//   cnt_clr_n    out  1      active-low counter clear
//   running      out  1      high while in RUN
//   done         out  1      high while in DONE
//   wraps        out  8      auto-reload wrap count, sticks at 255
//   state        out  2      FSM state (IDLE=00 RUN=01 PAUSE=10 DONE=11)
//
//  PRESCALE must be at least 2. PS_W is derived from it and should be left
//  at its default.
// ---------------------------------------------------------------------------
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int PRESCALE = 50000,
   parameter int PS_W     = $clog2(PRESCALE)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] terminal,
   input  logic [WIDTH-1:0] count,
   output logic             cnt_en,
   output logic             cnt_clr_n,
   output logic             running,
   output logic             done,
   output logic [7:0]       wraps,
   output logic [1:0]       state
);

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [WIDTH-1:0] term_q;
   logic [WIDTH-1:0] term_d;
   logic [7:0]       wraps_d;
   logic             cnt_en_d;
   logic             cnt_clr_n_d;
   logic             run_en;
   logic             restart;
   logic             tick;
   logic             match;

   // The prescaler only advances on cycles where the FSM stays in RUN.
   // A pause, stop or terminal match freezes it on the same edge that the
   // state changes.
   rate_divider #(
      .PRESCALE (PRESCALE),
      .PS_W     (PS_W)
   ) u_rate_divider (
      .clock   (clock),
      .clear   (clear),
      .run     (run_en),
      .restart (restart),
      .tick    (tick)
   );

   // While the counter is being cleared, its Q value is stale. The compare
   // is ignored on that cycle, so a zero terminal only matches once the
   // counter has really been cleared.
   assign match = cnt_clr_n && (count == term_q);

   // Next-state logic. Command priority is stop > pause > start. A command
   // that means nothing in the current state is ignored, so it falls through
   // to the next lower-priority one. A fresh start (from IDLE or DONE)
   // relatches the terminal, zeroes the prescaler and the wrap count, and
   // pulses the counter clear for one cycle. A resume from PAUSE touches
   // none of those. Enable pulses are produced only on cycles that stay in
   // RUN with no match. This keeps the counter from overshooting the
   // terminal when a tick lands on the match cycle.
   always_comb begin
      state_d     = state_q;
      term_d      = term_q;
      wraps_d     = wraps;
      cnt_en_d    = 1'b0;
      cnt_clr_n_d = 1'b1;
      run_en      = 1'b0;
      restart     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_RUN;
               term_d      = terminal;
               wraps_d     = 8'd0;
               restart     = 1'b1;
               cnt_clr_n_d = 1'b0;
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d     = ST_IDLE;
               restart     = 1'b1;
               cnt_clr_n_d = 1'b0;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (match) begin
               state_d = ST_DONE;
            end else begin
               run_en   = 1'b1;
               cnt_en_d = tick;
            end
         end

         ST_PAUSE: begin
            if (stop) begin
               state_d     = ST_IDLE;
               restart     = 1'b1;
               cnt_clr_n_d = 1'b0;
            end else if (start) begin
               state_d = ST_RUN;
            end
         end

         ST_DONE: begin
            if (stop) begin
               state_d     = ST_IDLE;
               restart     = 1'b1;
               cnt_clr_n_d = 1'b0;
            end else if (start) begin
               state_d     = ST_RUN;
               term_d      = terminal;
               wraps_d     = 8'd0;
               restart     = 1'b1;
               cnt_clr_n_d = 1'b0;
            end else if (auto_reload) begin
               state_d     = ST_RUN;
               wraps_d     = wrap_inc(wraps);
               restart     = 1'b1;
               cnt_clr_n_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset holds the counter in clear
   // (cnt_clr_n=0). Clear is released on the first clock after reset
   // because the default next value of cnt_clr_n is 1. The latched terminal
   // is deliberately lost on reset.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= ST_IDLE;
         term_q    <= '0;
         wraps     <= 8'd0;
         cnt_en    <= 1'b0;
         cnt_clr_n <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         term_q    <= term_d;
         wraps     <= wraps_d;
         cnt_en    <= cnt_en_d;
         cnt_clr_n <= cnt_clr_n_d;
         running   <= (state_d == ST_RUN);
         done      <= (state_d == ST_DONE);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//  Directed bench for counter_sequencer with PRESCALE=4 and WIDTH=16. A
//  behavioural 16-bit up-counter stands in for the counter datapath. It
//  increments on cnt_en and is held at zero while cnt_clr_n is low. Inputs
//  are driven on the falling edge and outputs are sampled there, half a
//  cycle away from the active edge. "k cycles after start" means k rising
//  edges after the edge that sampled the start pulse.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        pause;
   logic        stop;
   logic        auto_reload;
   logic [15:0] terminal;
   logic [15:0] count;
   logic        cnt_en;
   logic        cnt_clr_n;
   logic        running;
   logic        done;
   logic [7:0]  wraps;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   counter_sequencer #(
      .WIDTH    (16),
      .PRESCALE (4)
   ) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .pause       (pause),
      .stop        (stop),
      .auto_reload (auto_reload),
      .terminal    (terminal),
      .count       (count),
      .cnt_en      (cnt_en),
      .cnt_clr_n   (cnt_clr_n),
      .running     (running),
      .done        (done),
      .wraps       (wraps),
      .state       (state)
   );

   // Stand-in for the counter datapath: asynchronous active-low clear,
   // increment by one on each enabled clock.
   always @(posedge clock or negedge cnt_clr_n) begin
      if (!cnt_clr_n) begin
         count <= 16'd0;
      end else if (cnt_en) begin
         count <= count + 16'd1;
      end
   end

   // Advance to the next falling edge, one active edge later.
   task automatic tick_clock;
      @(posedge clock);
      @(negedge clock);
   endtask

   // Reset is held for a few clocks, then released.
   task automatic test_reset;
      clear = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
      auto_reload = 1'b0; terminal = 16'd0;
      repeat (3) tick_clock;
      checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b expected %b", state, 2'b00); end
      checks++; if (cnt_clr_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_low: got %b expected 0", cnt_clr_n); end
      checks++; if (cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnt_en: got %b expected 0", cnt_en); end
      checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: running %b done %b expected 0 0", running, done); end
      checks++; if (wraps !== 8'd0) begin errors++; $display("[TB] FAIL reset_wraps: got %0d expected 0", wraps); end
      clear = 1'b1;
      tick_clock;
      checks++; if (cnt_clr_n !== 1'b1) begin errors++; $display("[TB] FAIL release_clr_high: got %b expected 1", cnt_clr_n); end
      checks++; if (state !== 2'b00 || count !== 16'd0) begin errors++; $display("[TB] FAIL release_idle: state %b count %0d expected 00 0", state, count); end
   endtask

   // terminal=3: steps at 4, 8 and 12 cycles after start. count reaches 3 at
   // edge 13, the match is seen on that cycle, and DONE follows at edge 14.
   task automatic test_start_to_done;
      int pulses;
      int pulse_at [3];
      int done_at;
      int bad;
      int exp_at;
      pulses = 0; done_at = -1; bad = 0;
      pulse_at = '{0, 0, 0};
      terminal = 16'd3; start = 1'b1;
      tick_clock;
      start = 1'b0;
      checks++; if (state !== 2'b01 || cnt_clr_n !== 1'b0) begin errors++; $display("[TB] FAIL start_entry: state %b clr_n %b expected 01 0", state, cnt_clr_n); end
      for (int k = 1; k <= 16; k++) begin
         tick_clock;
         if (cnt_en === 1'b1) begin
            if (pulses < 3) pulse_at[pulses] = k;
            pulses++;
         end
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      checks++; if (pulses != 3) begin errors++; $display("[TB] FAIL step_count: got %0d expected 3", pulses); end
      for (int i = 0; i < 3; i++) begin
         exp_at = 4 * (i + 1);
         checks++; if (pulse_at[i] != exp_at) begin errors++; $display("[TB] FAIL step_timing[%0d]: got cycle %0d expected %0d", i, pulse_at[i], exp_at); end
      end
      checks++; if (done_at != 14) begin errors++; $display("[TB] FAIL done_timing: got cycle %0d expected 14", done_at); end
      checks++; if (state !== 2'b11 || count !== 16'd3) begin errors++; $display("[TB] FAIL done_state: state %b count %0d expected 11 3", state, count); end
      repeat (20) begin
         tick_clock;
         if (count !== 16'd3 || cnt_en !== 1'b0 || state !== 2'b11) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL done_hold: %0d bad cycles expected 0", bad); end
   endtask

   // terminal=10, started from DONE. Pause is sampled at edge 10, when the
   // prescaler holds 1 (it wrapped at edge 8). After resume the next step
   // is therefore 4-1=3 cycles later, and the one after that 4 cycles
   // further on.
   task automatic test_pause_resume;
      int pulses;
      int bad;
      int gap;
      pulses = 0; bad = 0; gap = -1;
      terminal = 16'd10; start = 1'b1;
      tick_clock;
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick_clock;
         if (cnt_en === 1'b1) pulses++;
      end
      checks++; if (pulses != 2 || count !== 16'd2) begin errors++; $display("[TB] FAIL pre_pause: steps %0d count %0d expected 2 2", pulses, count); end
      pause = 1'b1;
      tick_clock;
      pause = 1'b0;
      checks++; if (state !== 2'b10 || running !== 1'b0) begin errors++; $display("[TB] FAIL pause_entry: state %b running %b expected 10 0", state, running); end
      repeat (9) begin
         tick_clock;
         if (count !== 16'd2 || cnt_en !== 1'b0 || state !== 2'b10) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL pause_hold: %0d bad cycles expected 0", bad); end
      start = 1'b1;
      tick_clock;
      start = 1'b0;
      checks++; if (state !== 2'b01) begin errors++; $display("[TB] FAIL resume_state: got %b expected 01", state); end
      for (int k = 1; k <= 8; k++) begin
         tick_clock;
         if (cnt_en === 1'b1 && gap < 0) gap = k;
      end
      checks++; if (gap != 3) begin errors++; $display("[TB] FAIL resume_gap: got %0d cycles expected 3", gap); end
      checks++; if (count !== 16'd4) begin errors++; $display("[TB] FAIL resume_count: got %0d expected 4", count); end
      stop = 1'b1;
      tick_clock;
      stop = 1'b0;
      checks++; if (state !== 2'b00 || cnt_clr_n !== 1'b0 || count !== 16'd0) begin errors++; $display("[TB] FAIL stop_run: state %b clr_n %b count %0d expected 00 0 0", state, cnt_clr_n, count); end
      tick_clock;
      checks++; if (cnt_clr_n !== 1'b1) begin errors++; $display("[TB] FAIL stop_clr_pulse: got %b expected 1", cnt_clr_n); end
   endtask

   // terminal=2 with auto-reload: the count goes 0,1,2,0,1,2,... and wraps
   // follows each reload. Repeated for 300 DONE entries, wraps must stick
   // at 255. A later stop keeps the value.
   task automatic test_auto_reload;
      int over;
      int budget;
      int n_done;
      logic prev_done;
      over = 0;
      terminal = 16'd2; auto_reload = 1'b1; start = 1'b1;
      tick_clock;
      start = 1'b0;
      for (int w = 1; w <= 3; w++) begin
         budget = 0;
         while (done !== 1'b1 && budget < 40) begin
            tick_clock;
            budget++;
            if (count > 16'd2) over++;
         end
         checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL reload_done_timeout[%0d]: done %b expected 1", w, done); end
         checks++; if (count !== 16'd2) begin errors++; $display("[TB] FAIL reload_top[%0d]: count %0d expected 2", w, count); end
         tick_clock;
         checks++; if (state !== 2'b01 || cnt_clr_n !== 1'b0 || count !== 16'd0) begin errors++; $display("[TB] FAIL reload_restart[%0d]: state %b clr_n %b count %0d expected 01 0 0", w, state, cnt_clr_n, count); end
         checks++; if (wraps !== 8'(w)) begin errors++; $display("[TB] FAIL reload_wraps[%0d]: got %0d expected %0d", w, wraps, w); end
      end
      checks++; if (over != 0) begin errors++; $display("[TB] FAIL reload_overshoot: %0d cycles above 2 expected 0", over); end
      n_done = 3; budget = 0; prev_done = done;
      while (n_done < 300 && budget < 6000) begin
         tick_clock;
         budget++;
         if (done === 1'b1 && prev_done !== 1'b1) n_done++;
         prev_done = done;
      end
      checks++; if (n_done != 300) begin errors++; $display("[TB] FAIL wrap_run_timeout: got %0d done entries expected 300", n_done); end
      tick_clock;
      checks++; if (wraps !== 8'd255) begin errors++; $display("[TB] FAIL wraps_saturate: got %0d expected 255", wraps); end
      auto_reload = 1'b0; stop = 1'b1;
      tick_clock;
      stop = 1'b0;
      checks++; if (state !== 2'b00 || wraps !== 8'd255) begin errors++; $display("[TB] FAIL stop_keeps_wraps: state %b wraps %0d expected 00 255", state, wraps); end
   endtask

   // stop, pause and start together during RUN: stop wins.
   task automatic test_simultaneous_cmds;
      terminal = 16'd10; start = 1'b1;
      tick_clock;
      start = 1'b0;
      checks++; if (wraps !== 8'd0) begin errors++; $display("[TB] FAIL start_clears_wraps: got %0d expected 0", wraps); end
      repeat (6) tick_clock;
      checks++; if (running !== 1'b1 || count !== 16'd1) begin errors++; $display("[TB] FAIL mid_run: running %b count %0d expected 1 1", running, count); end
      stop = 1'b1; pause = 1'b1; start = 1'b1;
      tick_clock;
      stop = 1'b0; pause = 1'b0; start = 1'b0;
      checks++; if (state !== 2'b00 || running !== 1'b0) begin errors++; $display("[TB] FAIL priority_state: state %b running %b expected 00 0", state, running); end
      checks++; if (cnt_clr_n !== 1'b0 || count !== 16'd0) begin errors++; $display("[TB] FAIL priority_clear: clr_n %b count %0d expected 0 0", cnt_clr_n, count); end
      tick_clock;
      checks++; if (cnt_clr_n !== 1'b1 || state !== 2'b00) begin errors++; $display("[TB] FAIL priority_settle: clr_n %b state %b expected 1 00", cnt_clr_n, state); end
   endtask

   // terminal=0 reaches DONE at edge 2 with no steps. Auto-reload then
   // builds up wraps, and an asynchronous clear in RUN drops everything back
   // to reset values at once.
   task automatic test_zero_and_clear;
      int pulses;
      int done_at;
      int budget;
      pulses = 0; done_at = -1; budget = 0;
      terminal = 16'd0; auto_reload = 1'b0; start = 1'b1;
      tick_clock;
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick_clock;
         if (cnt_en === 1'b1) pulses++;
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL zero_term_steps: got %0d expected 0", pulses); end
      checks++; if (done_at != 2 || state !== 2'b11) begin errors++; $display("[TB] FAIL zero_term_done: cycle %0d state %b expected 2 11", done_at, state); end
      auto_reload = 1'b1;
      while (!(running === 1'b1 && wraps >= 8'd2) && budget < 40) begin
         tick_clock;
         budget++;
      end
      checks++; if (running !== 1'b1 || wraps < 8'd2) begin errors++; $display("[TB] FAIL pre_clear_timeout: running %b wraps %0d expected 1 >=2", running, wraps); end
      clear = 1'b0;
      #1;
      checks++; if (state !== 2'b00 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL async_clear_state: state %b running %b done %b expected 00 0 0", state, running, done); end
      checks++; if (wraps !== 8'd0 || cnt_en !== 1'b0 || cnt_clr_n !== 1'b0 || count !== 16'd0) begin errors++; $display("[TB] FAIL async_clear_outputs: wraps %0d en %b clr_n %b count %0d expected 0 0 0 0", wraps, cnt_en, cnt_clr_n, count); end
      auto_reload = 1'b0;
      tick_clock;
      clear = 1'b1;
      tick_clock;
      checks++; if (cnt_clr_n !== 1'b1 || state !== 2'b00) begin errors++; $display("[TB] FAIL clear_release: clr_n %b state %b expected 1 00", cnt_clr_n, state); end
   endtask

   initial begin
      $display("[TB] counter_sequencer directed tests, PRESCALE=4");
      test_reset;
      test_start_to_done;
      test_pause_resume;
      test_auto_reload;
      test_simultaneous_cmds;
      test_zero_and_clear;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
